fifo_prog_flags: RTL

Parametrised synchronous FIFO, the next-generation buffer for the accelerator datapaths. It adds a first-word-fall-through (FWFT) read mode, runtime-programmable almost-full/almost-empty thresholds, an occupancy output, synchronous flush and sticky overflow/underflow error flags. It sits between producer and consumer engines in the same clock domain and drops into any existing FIFO slot without changing the surrounding interface.

---
 rtl/fifo_prog_flags.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_prog_flags.sv
// Synchronous FIFO with optional first-word-fall-through output, programmable
// almost-full/almost-empty thresholds, occupancy count, flush and sticky error flags.
module fifo_prog_flags #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter bit FWFT       = 1'b0,
  parameter     TYPE       = "block"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_write_req,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  output logic                  s_write_ready,
  input  logic                  s_read_req,
  output logic [DATA_WIDTH-1:0] s_read_data,
  output logic                  s_read_ready,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);

  (* ram_style = TYPE *) logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  full, empty, wr_acc, rd_acc;

  assign full          = (fifo_count == DEPTH_C);
  assign empty         = (fifo_count == '0);
  assign s_write_ready = !full;
  assign s_read_ready  = !empty;

  // Flush wins over both requests, so neither is accepted in that cycle.
  assign wr_acc = s_write_req && !full  && !flush;
  assign rd_acc = s_read_req  && !empty && !flush;

  always_comb begin
    count_nxt  = fifo_count;
    rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(rd_acc);
    if (flush) begin
      count_nxt  = '0;
      rd_ptr_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = fifo_count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = fifo_count - 1'b1;
    end
  end

  // Next head word: bypass the incoming word when it lands exactly at the new head.
  assign head_nxt = (wr_acc && (wr_ptr == rd_ptr_nxt)) ? s_write_data : mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= s_write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= flush ? '0 : wr_ptr + ADDR_WIDTH'(wr_acc);
      rd_ptr       <= rd_ptr_nxt;
      fifo_count   <= count_nxt;
      almost_full  <= (count_nxt >= af_thresh);
      almost_empty <= (count_nxt <= ae_thresh);
      // A new error in the same cycle as clear_err keeps the flag set.
      overflow     <= (s_write_req && full  && !flush) || (overflow  && !clear_err);
      underflow    <= (s_read_req  && empty && !flush) || (underflow && !clear_err);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_read_data <= '0;
    end else if (FWFT) begin
      if (!flush && (count_nxt != '0)) s_read_data <= head_nxt;
    end else begin
      if (rd_acc) s_read_data <= mem[rd_ptr];
    end
  end

endmodule
